// File: rtl/fp8_pkg.sv
// Shared types and constants for the FP8 (1-3-4, bias 3) matrix-product sequencer.
package fp8_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MUL   = 3'd1,
    ACC   = 3'd2,
    STORE = 3'd3,
    DONE  = 3'd4
  } mm_state_e;

  localparam logic [7:0] FP8_ZERO = 8'h00;
  localparam logic [7:0] FP8_ONE  = 8'h30;
  localparam logic [7:0] FP8_TWO  = 8'h40;
  localparam int         FP8_BIAS = 3;

  localparam int FP8_SIGN_BIT = 7;
  localparam int FP8_EXP_MSB  = 6;
  localparam int FP8_EXP_LSB  = 4;
  localparam int FP8_MAN_MSB  = 3;
  localparam int FP8_MAN_LSB  = 0;

  function automatic logic fp8_is_zero(input logic [7:0] x);
    return (x == FP8_ZERO);
  endfunction

endpackage

// File: rtl/fp8_mm_index_counter.sv
// Nested i/j/k loop counters; k is the inner reduction index, (i,j) walk C row-major.
module fp8_mm_index_counter
  import fp8_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_i,
  input  logic          k_inc_i,
  input  logic          ij_step_i,
  output logic [IW-1:0] i_o,
  output logic [IW-1:0] j_o,
  output logic [IW-1:0] k_o,
  output logic          k_last_o,
  output logic          ij_last_o
);

  localparam logic [IW-1:0] LAST = IW'(N - 1);
  localparam logic [IW-1:0] ONE  = IW'(1);

  logic [IW-1:0] i_q, i_d;
  logic [IW-1:0] j_q, j_d;
  logic [IW-1:0] k_q, k_d;

  assign i_o       = i_q;
  assign j_o       = j_q;
  assign k_o       = k_q;
  assign k_last_o  = (k_q == LAST);
  assign ij_last_o = (i_q == LAST) && (j_q == LAST);

  // Counters only wrap through an (i,j) step, so none can exceed N-1.
  always_comb begin
    i_d = i_q;
    j_d = j_q;
    k_d = k_q;
    if (clear_i) begin
      i_d = '0;
      j_d = '0;
      k_d = '0;
    end else if (ij_step_i) begin
      k_d = '0;
      if (j_q == LAST) begin
        j_d = '0;
        i_d = (i_q == LAST) ? '0 : i_q + ONE;
      end else begin
        j_d = j_q + ONE;
      end
    end else if (k_inc_i && !k_last_o) begin
      k_d = k_q + ONE;
    end else begin
      k_d = k_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i_q <= '0;
      j_q <= '0;
      k_q <= '0;
    end else begin
      i_q <= i_d;
      j_q <= j_d;
      k_q <= k_d;
    end
  end

endmodule

// File: rtl/fp8_matmul_sequencer.sv
// C = A x B sequencer over FP8 elements, time-sharing one external multiplier and adder.
module fp8_matmul_sequencer
  import fp8_pkg::*;
#(
  parameter int N  = 2,
  parameter int W  = 8,
  parameter int AW = $clog2(N*N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic          wr_sel,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          start,
  output logic          busy,
  output logic          done,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data,
  output logic [W-1:0]  mul_in1,
  output logic [W-1:0]  mul_in2,
  input  logic [W-1:0]  mul_out,
  output logic [W-1:0]  add_in1,
  output logic [W-1:0]  add_in2,
  input  logic [W-1:0]  add_out
);

  localparam int            IW    = (N > 1) ? $clog2(N) : 1;
  localparam int            DEPTH = 2**AW;
  localparam logic [AW-1:0] N_A   = AW'(N);

  mm_state_e     state_q, state_d;
  logic [W-1:0]  prod_q, prod_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  a_q [DEPTH];
  logic [W-1:0]  b_q [DEPTH];
  logic [W-1:0]  c_q [DEPTH];

  logic [IW-1:0] idx_i, idx_j, idx_k;
  logic          k_last, ij_last;
  logic          cnt_clear, k_inc, ij_step, c_we, host_we;

  function automatic logic [AW-1:0] flat(input logic [IW-1:0] r, input logic [IW-1:0] c);
    return AW'(r) * N_A + AW'(c);
  endfunction

  fp8_mm_index_counter #(.N(N), .IW(IW)) u_idx (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (cnt_clear),
    .k_inc_i  (k_inc),
    .ij_step_i(ij_step),
    .i_o      (idx_i),
    .j_o      (idx_j),
    .k_o      (idx_k),
    .k_last_o (k_last),
    .ij_last_o(ij_last)
  );

  // Padding entries beyond N*N are never written, so they read as zero.
  assign host_we = wr_en && (state_q == IDLE) && (int'(wr_addr) < N*N);

  assign mul_in1 = a_q[flat(idx_i, idx_k)];
  assign mul_in2 = b_q[flat(idx_k, idx_j)];
  assign add_in1 = acc_q;
  assign add_in2 = prod_q;
  assign rd_data = c_q[rd_addr];
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);

  always_comb begin
    state_d   = state_q;
    prod_d    = prod_q;
    acc_d     = acc_q;
    cnt_clear = 1'b0;
    k_inc     = 1'b0;
    ij_step   = 1'b0;
    c_we      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_clear = 1'b1;
          state_d   = MUL;
        end else begin
          state_d = IDLE;
        end
      end
      MUL: begin
        prod_d  = mul_out;
        state_d = ACC;
      end
      ACC: begin
        // First product bypasses the adder so a stale accumulator never leaks in.
        acc_d = (idx_k == '0) ? prod_q : add_out;
        if (k_last) begin
          state_d = STORE;
        end else begin
          k_inc   = 1'b1;
          state_d = MUL;
        end
      end
      STORE: begin
        c_we    = 1'b1;
        ij_step = 1'b1;
        state_d = ij_last ? DONE : MUL;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      prod_q  <= FP8_ZERO;
      acc_q   <= FP8_ZERO;
    end else begin
      state_q <= state_d;
      prod_q  <= prod_d;
      acc_q   <= acc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < DEPTH; n++) begin
        a_q[n] <= FP8_ZERO;
        b_q[n] <= FP8_ZERO;
        c_q[n] <= FP8_ZERO;
      end
    end else begin
      if (host_we && !wr_sel) a_q[wr_addr] <= wr_data;
      if (host_we && wr_sel)  b_q[wr_addr] <= wr_data;
      if (c_we)               c_q[flat(idx_i, idx_j)] <= acc_q;
    end
  end

endmodule

// File: tb/tb_fp8_matmul_sequencer.sv
// Scoreboard bench: stimulus queues expectations, a negedge monitor compares them.
module tb_fp8_matmul_sequencer;

  logic clk;
  logic rst;

  logic       wr_en, wr_sel, start, busy, done;
  logic [1:0] wr_addr, rd_addr;
  logic [7:0] wr_data, rd_data, mul_in1, mul_in2, mul_out, add_in1, add_in2, add_out;

  logic       wr_en3, wr_sel3, start3, busy3, done3;
  logic [3:0] wr_addr3, rd_addr3;
  logic [7:0] wr_data3, rd_data3, mul_in1_3, mul_in2_3, mul_out3, add_in1_3, add_in2_3, add_out3;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int         kind;
    logic [7:0] exp;
    string      name;
  } probe_t;

  int          done_q2[$];
  int          done_q3[$];
  logic [15:0] op_q[$];
  probe_t      probe_q[$];
  bit          probe_req = 1'b0;
  bit          opchk_en  = 1'b0;
  bit          len_chk   = 1'b1;
  bit          busy_prev = 1'b0;
  int          rc        = 0;
  logic [7:0]  last_mul  = 8'h00;

  fp8_matmul_sequencer #(.N(2)) dut2 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .busy(busy), .done(done), .rd_addr(rd_addr),
    .rd_data(rd_data), .mul_in1(mul_in1), .mul_in2(mul_in2), .mul_out(mul_out),
    .add_in1(add_in1), .add_in2(add_in2), .add_out(add_out)
  );

  fp8_matmul_sequencer #(.N(3)) dut3 (
    .clk(clk), .rst(rst), .wr_en(wr_en3), .wr_sel(wr_sel3), .wr_addr(wr_addr3),
    .wr_data(wr_data3), .start(start3), .busy(busy3), .done(done3), .rd_addr(rd_addr3),
    .rd_data(rd_data3), .mul_in1(mul_in1_3), .mul_in2(mul_in2_3), .mul_out(mul_out3),
    .add_in1(add_in1_3), .add_in2(add_in2_3), .add_out(add_out3)
  );

  // Ideal minifloat reference: decode to real, compute, round to nearest and re-encode.
  function automatic real fp8_dec(input logic [7:0] x);
    real m;
    int  e;
    if (x == 8'h00) return 0.0;
    m = 1.0 + real'(int'(x[3:0])) / 16.0;
    e = int'(x[6:4]) - 3;
    for (int n = 0; n < e; n++) m = m * 2.0;
    for (int n = 0; n < -e; n++) m = m / 2.0;
    return x[7] ? -m : m;
  endfunction

  function automatic logic [7:0] fp8_enc(input real v);
    real  a;
    int   ue;
    int   be;
    int   man;
    logic s;
    if (v == 0.0) return 8'h00;
    s  = (v < 0.0);
    a  = s ? -v : v;
    ue = 0;
    while (a >= 2.0) begin a = a / 2.0; ue++; end
    while (a < 1.0) begin a = a * 2.0; ue--; end
    man = int'((a - 1.0) * 16.0);
    if (man >= 16) begin man = 0; ue++; end
    be = ue + 3;
    if (be > 7) return {s, 7'h7F};
    if (be < 0) return 8'h00;
    return {s, 3'(be), 4'(man)};
  endfunction

  always_comb mul_out  = fp8_enc(fp8_dec(mul_in1) * fp8_dec(mul_in2));
  always_comb add_out  = fp8_enc(fp8_dec(add_in1) + fp8_dec(add_in2));
  always_comb mul_out3 = fp8_enc(fp8_dec(mul_in1_3) * fp8_dec(mul_in2_3));
  always_comb add_out3 = fp8_enc(fp8_dec(add_in1_3) + fp8_dec(add_in2_3));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: done timing, operand sequence, busy span and queued read-back probes.
  always @(negedge clk) begin
    if (done) begin
      if (done_q2.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_done N=2 at cycle %0d", cyc);
      end else begin
        chk("done_cycle_n2", cyc, done_q2.pop_front());
      end
    end
    if (done3) begin
      if (done_q3.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_done N=3 at cycle %0d", cyc);
      end else begin
        chk("done_cycle_n3", cyc, done_q3.pop_front());
      end
    end
    if (busy) begin
      rc = busy_prev ? rc + 1 : 0;
      if (opchk_en && rc < 20 && (rc % 5 == 0 || rc % 5 == 2)) begin
        if (op_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL mul_operands: extra MUL cycle rc=%0d", rc);
        end else begin
          chk("mul_operands", {mul_in1, mul_in2}, op_q.pop_front());
        end
        last_mul = mul_out;
      end else if (opchk_en && rc < 20 && (rc % 5 == 1 || rc % 5 == 3)) begin
        chk("add_in2_is_prev_product", add_in2, last_mul);
      end
    end else if (busy_prev && len_chk) begin
      chk("busy_span", rc, 20);
    end
    busy_prev = busy;
    if (probe_req && probe_q.size() > 0) begin
      probe_t p;
      p = probe_q.pop_front();
      case (p.kind)
        0:       chk(p.name, rd_data, p.exp);
        1:       chk(p.name, {busy, done}, p.exp);
        default: chk(p.name, rd_data3, p.exp);
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr2(input bit sel, input int addr, input logic [7:0] d);
    wr_en = 1'b1; wr_sel = sel; wr_addr = 2'(addr); wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wr3(input bit sel, input int addr, input logic [7:0] d);
    wr_en3 = 1'b1; wr_sel3 = sel; wr_addr3 = 4'(addr); wr_data3 = d;
    tick();
    wr_en3 = 1'b0;
  endtask

  task automatic start2(input bit expect_done);
    start = 1'b1;
    if (expect_done) done_q2.push_back(cyc + 1 + 20);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle2();
    int n = 0;
    while (busy && n < 200) begin tick(); n++; end
    chk("run_completes_n2", busy, 0);
  endtask

  task automatic wait_idle3();
    int n = 0;
    while (busy3 && n < 300) begin tick(); n++; end
    chk("run_completes_n3", busy3, 0);
  endtask

  task automatic probe(input int kind, input string name, input int addr, input logic [7:0] e);
    if (kind == 2) rd_addr3 = 4'(addr);
    else           rd_addr  = 2'(addr);
    probe_q.push_back('{kind, e, name});
    probe_req = 1'b1;
    tick();
    probe_req = 1'b0;
  endtask

  task automatic probe_c2(input string name, input logic [31:0] c);
    for (int n = 0; n < 4; n++) probe(0, name, n, c[31-8*n -: 8]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0; rd_addr = '0;
    wr_en3 = 1'b0; wr_sel3 = 1'b0; wr_addr3 = '0; wr_data3 = '0; start3 = 1'b0; rd_addr3 = '0;
    tick(); tick();
    rst = 1'b0;
    probe(1, "reset_busy_done", 0, 8'h00);
    probe(0, "reset_c0", 0, 8'h00);

    // Identity A times B, with the operand order traced.
    wr2(0, 0, 8'h30); wr2(0, 1, 8'h00); wr2(0, 2, 8'h00); wr2(0, 3, 8'h30);
    wr2(1, 0, 8'h40); wr2(1, 1, 8'h30); wr2(1, 2, 8'h30); wr2(1, 3, 8'h40);
    op_q = '{16'h3040, 16'h0030, 16'h3030, 16'h0040,
             16'h0040, 16'h3030, 16'h0030, 16'h3040};
    opchk_en = 1'b1;
    start2(1);
    wait_idle2();
    opchk_en = 1'b0;
    probe_c2("identity_c", 32'h40303040);

    // All ones: every element is 1+1.
    for (int n = 0; n < 4; n++) begin wr2(0, n, 8'h30); wr2(1, n, 8'h30); end
    for (int n = 0; n < 8; n++) op_q.push_back(16'h3030);
    opchk_en = 1'b1;
    start2(1);
    wait_idle2();
    opchk_en = 1'b0;
    probe_c2("all_ones_c", 32'h40404040);

    // A write during a run is dropped; the same write in IDLE lands.
    start2(1);
    repeat (5) tick();
    wr2(0, 0, 8'h40);
    wait_idle2();
    probe_c2("busy_write_ignored_c", 32'h40404040);
    wr2(0, 0, 8'h40);
    start2(1);
    wait_idle2();
    probe_c2("idle_write_committed_c", 32'h48484040);

    // Extra starts mid-run are ignored; restart on the first IDLE cycle is accepted.
    start2(1);
    repeat (3) tick();
    start = 1'b1; tick(); start = 1'b0;
    repeat (4) tick();
    start = 1'b1; tick(); tick(); start = 1'b0;
    wait_idle2();
    start2(1);
    wait_idle2();
    probe_c2("back_to_back_c", 32'h48484040);

    // Reset in ACC aborts the run, clears C and suppresses done.
    len_chk = 1'b0;
    start2(0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    probe(1, "abort_busy_done", 0, 8'h00);
    probe_c2("abort_c_cleared", 32'h00000000);
    repeat (25) tick();
    len_chk = 1'b1;

    // N=3: identity times B leaves B unchanged.
    for (int n = 0; n < 9; n++) begin
      wr3(0, n, (n % 4 == 0) ? 8'h30 : 8'h00);
      wr3(1, n, 8'h30 + 8'(n));
    end
    start3 = 1'b1;
    done_q3.push_back(cyc + 1 + 63);
    tick();
    start3 = 1'b0;
    wait_idle3();
    for (int n = 0; n < 9; n++) probe(2, "n3_c_equals_b", n, 8'h30 + 8'(n));

    chk("done_n2_all_seen", done_q2.size(), 0);
    chk("done_n3_all_seen", done_q3.size(), 0);
    chk("operands_all_seen", op_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
